// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM pipeline stage and the data memory.
interface data_mem_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        busy_wait;
  logic        misaligned;

  // Pipeline side: issues requests, watches stall and results.
  modport master (
    output address, write_data, mem_read, mem_write, func3,
    input  read_data, busy_wait, misaligned
  );

  // Memory side: serves requests.
  modport slave (
    input  address, write_data, mem_read, mem_write, func3,
    output read_data, busy_wait, misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data memory responder. A request (load or store level)
// stalls the pipeline for LATENCY cycles, then completes in a one-cycle DONE
// state where stores are committed and load results become visible.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit SINGLE = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Sign/zero extension of the addressed lane of a fetched word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'h000000, b};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = word;
    endcase
  endfunction

  // Merge store data into the addressed byte lanes of the current word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: r[{off, 3'b000} +: 8] = wdata[7:0];
      3'b001: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    store_merge = r;
  endfunction

  // Alignment check; store and load encodings differ for FUNC3 100/101.
  function automatic logic is_misaligned(input logic       store,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    logic byte_acc;
    logic half_acc;
    if (store) begin
      byte_acc = (f3 == 3'b000);
      half_acc = (f3 == 3'b001);
    end else begin
      byte_acc = (f3 == 3'b000) || (f3 == 3'b100);
      half_acc = (f3 == 3'b001) || (f3 == 3'b101);
    end
    if (byte_acc)      is_misaligned = 1'b0;
    else if (half_acc) is_misaligned = off[0];
    else               is_misaligned = (off != 2'b00);
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      read_data_q;
  logic             misaligned_q;

  logic             req;
  logic [AW-1:0]    word_idx;
  logic [1:0]       byte_off;
  logic [31:0]      cur_word;
  logic             mis_now;
  logic             commit;
  logic             wr_en;
  logic             unused_addr;

  assign req      = bus.mem_read | bus.mem_write;
  assign word_idx = bus.address[AW+1:2];
  assign byte_off = bus.address[1:0];
  assign cur_word = mem[word_idx];
  assign mis_now  = is_misaligned(bus.mem_write, bus.func3, byte_off);

  // Upper address bits are deliberately ignored: the store wraps.
  assign unused_addr = ^bus.address[31:AW+2];

  // The edge that enters DONE is the commit edge; a request that drops
  // before it turns the access into a flush.
  assign commit = req && ((state == IDLE && SINGLE) ||
                          (state == ACCESS && cnt == CNT_ONE));
  assign wr_en  = commit && bus.mem_write && !mis_now && !rst;

  // Stall is combinational so the pipeline freezes in the request cycle.
  assign bus.busy_wait  = !rst && ((state == IDLE && req) || state == ACCESS);
  assign bus.read_data  = read_data_q;
  assign bus.misaligned = misaligned_q;

  // Control FSM with latency counter and registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (SINGLE) begin
              state <= DONE;
            end else begin
              state <= ACCESS;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_ONE) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        misaligned_q <= mis_now;
        if (bus.mem_read && !bus.mem_write) begin
          read_data_q <= mis_now ? 32'h0000_0000
                                 : load_extend(cur_word, byte_off, bus.func3);
        end
      end
    end
  end

  // Storage array: byte-lane store commit, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_idx] <= store_merge(cur_word, bus.write_data, byte_off, bus.func3);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 instance exercised by directed
// and random accesses against a byte-array memory model, and a LATENCY=1
// instance for the back-to-back stall pattern.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if if0();
  data_mem_responder_if if1();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .bus(if0)
  );
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  mb [1024];
  logic [31:0] exp_rd;

  // Access size in bytes for the given direction and FUNC3.
  function automatic int size_of(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input bit st, input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(st, f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int b;
    int sz;
    sz = size_of(1'b0, f3);
    b  = int'(a[9:0]);
    v  = 32'h0;
    for (int k = 0; k < sz; k++) v = v | (32'(mb[b + k]) << (8 * k));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int b;
    int sz;
    logic [31:0] t;
    sz = size_of(1'b1, f3);
    if (model_mis(1'b1, f3, a)) return;
    b = int'(a[9:0]);
    t = wd;
    for (int k = 0; k < sz; k++) begin
      mb[b + k] = t[7:0];
      t = t >> 8;
    end
  endtask

  // Drive one access on the LATENCY=3 instance and observe it.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3,
                            output int bc, output logic [31:0] rdata,
                            output logic mis_done, output logic mis_after,
                            output bit to);
    bc = 0; to = 1'b1; rdata = '0; mis_done = 1'b0; mis_after = 1'b0;
    @(negedge clk);
    if0.address = a; if0.write_data = wd; if0.func3 = f3;
    if0.mem_read = rd; if0.mem_write = wr;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (if0.busy_wait) bc++;
      else begin
        rdata = if0.read_data; mis_done = if0.misaligned; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if0.mem_read = 1'b0; if0.mem_write = 1'b0;
    @(negedge clk);
    #1 mis_after = if0.misaligned;
  endtask

  task automatic test_reset();
    int bc;
    rst = 1'b1;
    if0.address = 32'h0; if0.write_data = 32'h0BAD_F00D; if0.func3 = 3'd2;
    if0.mem_read = 1'b0; if0.mem_write = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (if0.busy_wait !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", if0.busy_wait); end
    total++; if (if0.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", if0.read_data); end
    total++; if (if0.misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", if0.misaligned); end
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!if0.busy_wait) break;
      bc++;
      @(negedge clk);
    end
    if0.mem_write = 1'b0;
    model_store(32'h0, 32'h0BAD_F00D, 3'd2);
    exp_rd = 32'h0;
    total++; if (bc !== 3) begin bad++; $display("FAIL reset_release_busy: got %0d want 3", bc); end
  endtask

  task automatic test_init();
    int bc, nbad;
    logic [31:0] rdata, d;
    logic md, ma;
    bit to;
    nbad = 0;
    for (int w = 0; w < 256; w++) begin
      d = $urandom;
      run_access(1'b0, 1'b1, 32'(w * 4), d, 3'd2, bc, rdata, md, ma, to);
      model_store(32'(w * 4), d, 3'd2);
      if (bc != 3 || to) nbad++;
    end
    total++; if (nbad !== 0) begin bad++; $display("FAIL init_busy: got %0d bad stores want 0", nbad); end
  endtask

  task automatic test_basic();
    int bc;
    logic [31:0] rdata;
    logic md, ma;
    bit to;
    run_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, bc, rdata, md, ma, to);
    model_store(32'h10, 32'hDEAD_BEEF, 3'd2);
    total++; if (bc !== 3) begin bad++; $display("FAIL sw_busy: got %0d want 3", bc); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (bc !== 3) begin bad++; $display("FAIL lw_busy: got %0d want 3", bc); end
    total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", rdata); end
    exp_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_bytes();
    int bc;
    logic [31:0] rdata;
    logic md, ma;
    bit to;
    run_access(1'b0, 1'b1, 32'h10, 32'h1122_3344, 3'd2, bc, rdata, md, ma, to);
    model_store(32'h10, 32'h1122_3344, 3'd2);
    run_access(1'b0, 1'b1, 32'h11, 32'hABCD_EF80, 3'd0, bc, rdata, md, ma, to);
    model_store(32'h11, 32'hABCD_EF80, 3'd0);
    total++; if (rdata !== exp_rd) begin bad++; $display("FAIL sb_keeps_rdata: got %h want %h", rdata, exp_rd); end
    run_access(1'b1, 1'b0, 32'h11, 32'h0, 3'd0, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb: got %h want ffffff80", rdata); end
    run_access(1'b1, 1'b0, 32'h11, 32'h0, 3'd4, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu: got %h want 00000080", rdata); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'h1122_8044) begin bad++; $display("FAIL lw_after_sb: got %h want 11228044", rdata); end
    exp_rd = rdata;
  endtask

  task automatic test_misaligned();
    int bc;
    logic [31:0] rdata;
    logic md, ma;
    bit to;
    run_access(1'b1, 1'b0, 32'h13, 32'h0, 3'd1, bc, rdata, md, ma, to);
    total++; if (md !== 1'b1) begin bad++; $display("FAIL lh_mis_flag: got %b want 1", md); end
    total++; if (ma !== 1'b0) begin bad++; $display("FAIL lh_mis_pulse: got %b want 0", ma); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL lh_mis_data: got %h want 00000000", rdata); end
    total++; if (bc !== 3) begin bad++; $display("FAIL lh_mis_busy: got %0d want 3", bc); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'h1122_8044) begin bad++; $display("FAIL mem_after_lh: got %h want 11228044", rdata); end
    run_access(1'b0, 1'b1, 32'h12, 32'hCAFE_BABE, 3'd2, bc, rdata, md, ma, to);
    total++; if (md !== 1'b1) begin bad++; $display("FAIL sw_mis_flag: got %b want 1", md); end
    total++; if (ma !== 1'b0) begin bad++; $display("FAIL sw_mis_pulse: got %b want 0", ma); end
    total++; if (rdata !== 32'h1122_8044) begin bad++; $display("FAIL sw_mis_rdata: got %h want 11228044", rdata); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'h1122_8044) begin bad++; $display("FAIL mem_after_sw_mis: got %h want 11228044", rdata); end
    exp_rd = 32'h1122_8044;
  endtask

  task automatic test_wrap();
    int bc;
    logic [31:0] rdata;
    logic md, ma;
    bit to;
    run_access(1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 3'd2, bc, rdata, md, ma, to);
    model_store(32'h400, 32'hA5A5_A5A5, 3'd2);
    run_access(1'b1, 1'b0, 32'h000, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrap_lw: got %h want a5a5a5a5", rdata); end
    exp_rd = rdata;
  endtask

  task automatic test_both_high();
    int bc;
    logic [31:0] rdata, d;
    logic md, ma;
    bit to;
    d = $urandom;
    run_access(1'b1, 1'b1, 32'h20, d, 3'd2, bc, rdata, md, ma, to);
    model_store(32'h20, d, 3'd2);
    total++; if (rdata !== exp_rd) begin bad++; $display("FAIL both_rdata: got %h want %h", rdata, exp_rd); end
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== d) begin bad++; $display("FAIL both_stored: got %h want %h", rdata, d); end
    exp_rd = rdata;
  endtask

  task automatic test_abort();
    int bc;
    logic [31:0] rdata, old30, old34;
    logic md, ma;
    bit to;
    old30 = model_load(32'h30, 3'd2);
    old34 = model_load(32'h34, 3'd2);
    // Flush: requests drop in the second busy cycle.
    @(negedge clk);
    if0.address = 32'h30; if0.write_data = ~old30; if0.func3 = 3'd2;
    if0.mem_write = 1'b1; if0.mem_read = 1'b0;
    @(negedge clk);
    if0.mem_write = 1'b0;
    @(negedge clk);
    #1;
    total++; if (if0.busy_wait !== 1'b0) begin bad++; $display("FAIL flush_idle: got %b want 0", if0.busy_wait); end
    total++; if (if0.read_data !== exp_rd) begin bad++; $display("FAIL flush_rdata: got %h want %h", if0.read_data, exp_rd); end
    total++; if (if0.misaligned !== 1'b0) begin bad++; $display("FAIL flush_mis: got %b want 0", if0.misaligned); end
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (bc !== 3) begin bad++; $display("FAIL flush_next_busy: got %0d want 3", bc); end
    total++; if (rdata !== old30) begin bad++; $display("FAIL flush_mem: got %h want %h", rdata, old30); end
    // Reset mid-store.
    @(negedge clk);
    if0.address = 32'h34; if0.write_data = ~old34; if0.func3 = 3'd2;
    if0.mem_write = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (if0.busy_wait !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", if0.busy_wait); end
    total++; if (if0.read_data !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata: got %h want 00000000", if0.read_data); end
    @(negedge clk);
    if0.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0;
    run_access(1'b1, 1'b0, 32'h34, 32'h0, 3'd2, bc, rdata, md, ma, to);
    total++; if (rdata !== old34) begin bad++; $display("FAIL rst_mid_mem: got %h want %h", rdata, old34); end
    exp_rd = rdata;
  endtask

  task automatic test_random();
    int bc, kind;
    logic [31:0] rdata, a, wd, exp_r;
    logic [2:0] f3;
    logic md, ma;
    bit to, rd, wr, emis;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      emis = model_mis(wr, f3, a);
      if (wr) begin
        model_store(a, wd, f3);
        exp_r = exp_rd;
      end else begin
        exp_r = emis ? 32'h0 : model_load(a, f3);
        exp_rd = exp_r;
      end
      run_access(rd, wr, a, wd, f3, bc, rdata, md, ma, to);
      total++; if (to || bc !== 3) begin bad++; $display("FAIL rnd_busy[%0d]: got %0d want 3", n, bc); end
      total++; if (rdata !== exp_r) begin bad++; $display("FAIL rnd_data[%0d] a=%h f3=%0d rd=%b wr=%b: got %h want %h", n, a, f3, rd, wr, rdata, exp_r); end
      total++; if (md !== emis) begin bad++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, md, emis); end
      total++; if (ma !== 1'b0) begin bad++; $display("FAIL rnd_mis_pulse[%0d]: got %b want 0", n, ma); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va, vb;
    va = $urandom; vb = $urandom;
    @(negedge clk);
    if1.address = 32'h40; if1.write_data = va; if1.func3 = 3'd2;
    if1.mem_write = 1'b1; if1.mem_read = 1'b0;
    #1;
    total++; if (if1.busy_wait !== 1'b1) begin bad++; $display("FAIL b2b_sw0_busy: got %b want 1", if1.busy_wait); end
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b0) begin bad++; $display("FAIL b2b_sw0_done: got %b want 0", if1.busy_wait); end
    if1.address = 32'h44; if1.write_data = vb;
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b1) begin bad++; $display("FAIL b2b_sw1_busy: got %b want 1", if1.busy_wait); end
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b0) begin bad++; $display("FAIL b2b_sw1_done: got %b want 0", if1.busy_wait); end
    if1.mem_write = 1'b0; if1.mem_read = 1'b1; if1.address = 32'h40;
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b1) begin bad++; $display("FAIL b2b_lw0_busy: got %b want 1", if1.busy_wait); end
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b0) begin bad++; $display("FAIL b2b_lw0_done: got %b want 0", if1.busy_wait); end
    total++; if (if1.read_data !== va) begin bad++; $display("FAIL b2b_lw0_data: got %h want %h", if1.read_data, va); end
    if1.address = 32'h44;
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b1) begin bad++; $display("FAIL b2b_lw1_busy: got %b want 1", if1.busy_wait); end
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b0) begin bad++; $display("FAIL b2b_lw1_done: got %b want 0", if1.busy_wait); end
    total++; if (if1.read_data !== vb) begin bad++; $display("FAIL b2b_lw1_data: got %h want %h", if1.read_data, vb); end
    if1.mem_read = 1'b0;
    @(negedge clk); #1;
    total++; if (if1.busy_wait !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", if1.busy_wait); end
  endtask

  initial begin
    rst = 1'b1;
    exp_rd = 32'h0;
    if0.address = '0; if0.write_data = '0; if0.func3 = '0;
    if0.mem_read = 1'b0; if0.mem_write = 1'b0;
    if1.address = '0; if1.write_data = '0; if1.func3 = '0;
    if1.mem_read = 1'b0; if1.mem_write = 1'b0;
    test_reset();
    test_init();
    test_basic();
    test_bytes();
    test_misaligned();
    test_wrap();
    test_both_high();
    test_abort();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning storage size in 32-bit words; power of 2, at least 4.
REQ-002 SHALL have parameter LATENCY, default 3, meaning cycles BUSY_WAIT stays high per access; at least 1.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port ADDRESS, input, 32 bits: byte address from the MEM stage.
REQ-006 SHALL have port WRITE_DATA, input, 32 bits: store data; low byte/half used for SB/SH.
REQ-007 SHALL have port MEM_READ, input, 1 bit: load request level.
REQ-008 SHALL have port MEM_WRITE, input, 1 bit: store request level.
REQ-009 SHALL have port FUNC3, input, 3 bits: access size and sign, per RV32I load/store encoding.
REQ-010 SHALL have port READ_DATA, output, 32 bits: registered load result, extended to 32 bits.
REQ-011 SHALL have port BUSY_WAIT, output, 1 bit: pipeline stall request, combinational.
REQ-012 SHALL have port MISALIGNED, output, 1 bit: one-cycle error flag in the completion cycle.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and DONE; a request is active when MEM_READ or MEM_WRITE is high.
REQ-014 SHALL require the initiator to hold ADDRESS, WRITE_DATA, FUNC3 and the request level stable while BUSY_WAIT is high.
REQ-015 SHALL drive BUSY_WAIT high in IDLE with an active request and in ACCESS, and low in DONE and in IDLE without a request.
REQ-016 SHALL hold BUSY_WAIT high for exactly LATENCY consecutive cycles, starting in the cycle the request first appears in IDLE.
REQ-017 SHALL move IDLE to ACCESS on a request, or IDLE to DONE directly when LATENCY = 1.
REQ-018 SHALL move ACCESS to DONE when the internal down-counter expires; the counter is loaded with LATENCY-1 on leaving IDLE.
REQ-019 SHALL move DONE to IDLE unconditionally on the next edge; a new request seen in that IDLE cycle starts a fresh access with no bubble.
REQ-020 SHALL abort ACCESS to IDLE if both request inputs drop, with no memory write and READ_DATA unchanged (flush case).
REQ-021 SHALL commit a store on the edge entering DONE, and load READ_DATA on that same edge.
REQ-022 SHALL hold READ_DATA until the next completed load; stores and aborted accesses leave READ_DATA unchanged.
REQ-023 SHALL give a store priority when MEM_READ and MEM_WRITE are both high; the read is ignored and READ_DATA is unchanged.
REQ-024 SHALL index words by ADDRESS[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-025 SHALL use little-endian byte lanes: byte k at bits [8k+7:8k], selected by ADDRESS[1:0].
REQ-026 SHALL decode loads as: FUNC3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-027 SHALL decode stores as: FUNC3 000 SB, 001 SH, 010 SW; only the addressed byte lanes are modified.
REQ-028 SHALL treat any other FUNC3 as a word access.
REQ-029 SHALL treat halfword accesses with ADDRESS[0]=1 and word accesses with ADDRESS[1:0]!=0 as misaligned.
REQ-030 SHALL, for a misaligned access, leave memory unmodified, load READ_DATA with 0 on a load, assert MISALIGNED in the DONE cycle, and keep the normal latency.

Reset
REQ-031 SHALL, while RST is high, force state IDLE, counter 0, READ_DATA 0x00000000, MISALIGNED 0 and BUSY_WAIT 0, regardless of request inputs.
REQ-032 SHALL abort any in-progress access when RST is asserted, committing no write.
REQ-033 SHALL leave storage contents unchanged by reset; contents are uninitialised at power-up.
REQ-034 SHALL treat a request held across reset release as new, starting a full LATENCY busy period.

Verification
REQ-035 Bench SHALL check: SW 0xDEADBEEF to 0x10, then LW 0x10 -> BUSY_WAIT high 3 cycles each; READ_DATA = 0xDEADBEEF in the load's DONE cycle.
REQ-036 Bench SHALL check: SB 0x80 to 0x11 over word 0x11223344, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0x11228044.
REQ-037 Bench SHALL check: LH at 0x13 -> MISALIGNED pulses 1 cycle, READ_DATA = 0, memory unchanged; SW at 0x12 -> no write, MISALIGNED pulses.
REQ-038 Bench SHALL check: with DEPTH_WORDS = 256, SW 0xA5A5A5A5 to 0x400, then LW 0x000 -> 0xA5A5A5A5 (wrap).
REQ-039 Bench SHALL check: store started, requests dropped in the 2nd busy cycle -> IDLE next edge, later LW of that address returns the old value; repeat with RST asserted mid-store -> same result, READ_DATA = 0.
REQ-040 Bench SHALL check: back-to-back LW, LW with LATENCY = 1 -> BUSY_WAIT pattern 1,0,1,0; each READ_DATA correct in its DONE cycle.
